// File: rtl/tristate_bus_responder_if.sv
// tristate_bus_responder_if: ack control and received-byte status of the single-wire bus responder
interface tristate_bus_responder_if #(parameter int DATA_W = 8);
    logic              ack_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              oe;
    modport slave  (input ack_en, output dout, dout_valid, busy, oe);
    modport master (output ack_en, input dout, dout_valid, busy, oe);
endinterface

// File: rtl/tristate_bus_responder.sv
// tristate_bus_responder: receives a start-framed LSB-first byte on a pulled-up single wire, then pulls it low to ACK
module tristate_bus_responder #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire                       bus_io,
    tristate_bus_responder_if.slave   bus
);
    localparam int CW       = $clog2(BIT_CYCLES + BIT_CYCLES / 2);
    localparam int BW       = $clog2(DATA_W + 1);
    localparam int TURN_LEN = BIT_CYCLES / 2 + BIT_CYCLES - 1;

    typedef enum logic [2:0] {IDLE, START, DATA, TURN, ACK} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, w_lim;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift, r_dout;
    logic              r_valid, r_ack_flag, r_oe;
    logic              w_rx, w_last, w_full;

    assign w_rx   = bus_io;
    assign bus_io = r_oe ? 1'b0 : 1'bz;
    assign w_lim  = r_state == START ? CW'(BIT_CYCLES / 2 - 1) :
                    r_state == TURN  ? CW'(TURN_LEN - 1) : CW'(BIT_CYCLES - 1);
    assign w_last = r_cnt == w_lim;
    assign w_full = r_bit == BW'(DATA_W);

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_rx ? IDLE : START;
            START:   w_next = w_last ? (w_rx ? IDLE : DATA) : START;
            DATA:    w_next = w_full ? TURN : DATA;
            TURN:    w_next = w_last ? ACK : TURN;
            ACK:     w_next = w_last ? IDLE : ACK;
            default: w_next = IDLE;
        endcase
    end

    // The byte shifts in at the top so the first (LSB) bit lands at position 0 after DATA_W samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_ack_flag <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_cnt   <= (r_state == IDLE || w_next != r_state || w_last) ? '0 : r_cnt + CW'(1);
            r_bit   <= r_state != DATA ? '0 : (w_last && !w_full) ? r_bit + BW'(1) : r_bit;
            r_valid <= r_state == DATA && w_full;
            r_oe    <= w_next == ACK && r_ack_flag;
            if (r_state == DATA && w_last && !w_full)
                r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            if (r_state == DATA && w_full) begin
                r_dout     <= r_shift;
                r_ack_flag <= bus.ack_en;
            end
        end
    end

    always_comb begin
        bus.busy       = r_state != IDLE;
        bus.oe         = r_oe;
        bus.dout       = r_dout;
        bus.dout_valid = r_valid;
    end
endmodule
